// File: rtl/mul32_seq_if.sv
// mul32_seq_if: request/result bundle for the sequential multiplier.
//   start      request, sampled only while the multiplier is idle
//   a, b       multiplicand / multiplier, latched on acceptance
//   sgn        signed-operation select (only with MUL_SIGNED_EN defined)
//   busy       high while a multiply is in flight or completing
//   done       one-cycle pulse, p valid in that cycle
//   p          64-bit product, held until the next accepted start
// Modports: master drives requests, slave is the multiplier.
interface mul32_seq_if;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
`ifdef MUL_SIGNED_EN
  logic        sgn;
`endif
  logic        busy;
  logic        done;
  logic [63:0] p;

  modport master (
    output start, a, b,
`ifdef MUL_SIGNED_EN
    output sgn,
`endif
    input  busy, done, p
  );

  modport slave (
    input  start, a, b,
`ifdef MUL_SIGNED_EN
    input  sgn,
`endif
    output busy, done, p
  );
endinterface

// File: rtl/mul32_seq.sv
// mul32_seq: sequential 32x32 -> 64-bit shift-and-add multiplier.
// One multiplier bit is retired per cycle through a 32-bit adder
// (a = hi, b = lo[0] ? mcand : 0, ci = 0); the adder carry-out becomes the
// new hi[31], so the running product never loses precision.
// Latency is fixed: start accepted at edge E, p written at E+32, done high
// for the following cycle, next acceptance possible at E+34.
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous active-high reset
//   bus   mul32_seq_if.slave (start, a, b, [sgn], busy, done, p)
// Configuration macro: MUL_SIGNED_EN adds the sgn input; with sgn=1 the
// operands are converted to magnitudes and the product is negated at the
// end when the operand signs differ.
module mul32_seq (
  input logic         clk,
  input logic         rst,
  mul32_seq_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [31:0] mcand;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [5:0]  cnt;
  logic [63:0] p_q;

  // Adder stage: the same function as the 32-bit ripple adder with ci=0.
  logic [31:0] add_b;
  logic [31:0] add_s;
  logic        add_co;
  logic [63:0] prod_nxt;

  assign add_b             = lo[0] ? mcand : 32'd0;
  assign {add_co, add_s}   = {1'b0, hi} + {1'b0, add_b};
  assign prod_nxt          = {add_co, add_s, lo[31:1]};

  // Operand conditioning at acceptance and final product selection.
  logic [31:0] a_in;
  logic [31:0] b_in;
  logic [63:0] p_final;

`ifdef MUL_SIGNED_EN
  logic neg;
  logic neg_in;

  // Two's-complement magnitude; 0x80000000 negates to itself, which read
  // as unsigned is exactly 2^31.
  always_comb begin
    a_in   = bus.a;
    b_in   = bus.b;
    neg_in = 1'b0;
    if (bus.sgn) begin
      a_in   = bus.a[31] ? (32'd0 - bus.a) : bus.a;
      b_in   = bus.b[31] ? (32'd0 - bus.b) : bus.b;
      neg_in = bus.a[31] ^ bus.b[31];
    end
  end

  assign p_final = neg ? (64'd0 - prod_nxt) : prod_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      neg <= 1'b0;
    end else if (state == IDLE && bus.start) begin
      neg <= neg_in;
    end
  end
`else
  assign a_in    = bus.a;
  assign b_in    = bus.b;
  assign p_final = prod_nxt;
`endif

  // State register.
  // NOTE: every clocked register uses non-blocking assignment so all flops
  // update from the same pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state and handshake outputs.
  // NOTE: defaults come first so every path assigns every output and no
  // latch is inferred.
  always_comb begin
    state_nxt = state;
    bus.busy  = 1'b0;
    bus.done  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) state_nxt = CALC;
      end
      CALC: begin
        bus.busy = 1'b1;
        if (cnt == 6'd31) state_nxt = DONE;
      end
      DONE: begin
        bus.busy  = 1'b1;
        bus.done  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath.
  // NOTE: all datapath registers, including p, are reset so an aborted
  // multiply leaves no stale result visible.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand <= 32'd0;
      hi    <= 32'd0;
      lo    <= 32'd0;
      cnt   <= 6'd0;
      p_q   <= 64'd0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            mcand <= a_in;
            lo    <= b_in;
            hi    <= 32'd0;
            cnt   <= 6'd0;
          end
        end
        CALC: begin
          {hi, lo} <= prod_nxt;
          cnt      <= cnt + 6'd1;
          if (cnt == 6'd31) p_q <= p_final;
        end
        default: ;
      endcase
    end
  end

  assign bus.p = p_q;

endmodule

// File: doc/mul32_seq.md
# mul32_seq

Sequential 32×32 → 64-bit shift-and-add multiplier that sits directly downstream of the team's 32-bit ripple adder (Adder32: a, b, ci, s, co). It drives that adder once per cycle with the running high partial product and the multiplicand, then consumes its 32-bit sum and carry-out. One multiplier bit is retired per cycle, and the result is presented with a start/done handshake. It is the multi-cycle multiply unit beside the ALU.

## Interface
Parameters:
- none. Width is fixed at 32-bit operands and a 64-bit product.

Ports:
- clk  in  1  single clock, rising-edge
- rst  in  1  reset, asynchronous, active-high
- start  in  1  request; sampled only in IDLE
- a  in  32  multiplicand; latched when start is accepted
- b  in  32  multiplier; latched when start is accepted
- sgn  in  1  signed-operation select; present only with MUL_SIGNED_EN
- busy  out  1  high in CALC and DONE
- done  out  1  one-cycle pulse; p is valid in this cycle
- p  out  64  product; holds its value until the next accepted start

## Operation
- Registers:
  - mcand[31:0]
  - hi[31:0]
  - lo[31:0]
  - cnt[5:0]
  - state: IDLE / CALC / DONE
- Adder instance inputs: a=hi, b=(lo[0] ? mcand : 0), ci=0.
- IDLE:
  - On start=1: mcand←a, lo←b, hi←0, cnt←0, go to CALC.
  - On start=0: stay in IDLE.
- CALC (one iteration per cycle):
  - {hi,lo} ← {co, s, lo[31:1]}. The carry-out becomes the new hi[31], so no precision is lost.
  - cnt←cnt+1.
  - When cnt==31 at the edge: write p←{hi,lo}-next and go to DONE.
- DONE:
  - done=1 for exactly one cycle, then go to IDLE.
- start is ignored in CALC and DONE. It has no effect and is not queued.
- Arithmetic is unsigned modulo 2^64. The product is exact and never overflows.
- Operand changes after acceptance have no effect.

## Timing
- Reset values:
  - state=IDLE, busy=0, done=0, p=0.
  - hi, lo, mcand, cnt = 0.
- Latency: start is accepted at edge E.
  - 32 CALC iterations occur at edges E+1 … E+32.
  - p is updated at edge E+32.
  - done=1 during the cycle between edges E+32 and E+33.
  - busy is high from after E until E+33.
- Earliest next acceptance is edge E+34, which gives a throughput of 1 multiply per 34 cycles.
- busy falls in the same edge that done falls.
- Reset asserted mid-operation:
  - Immediate return to the reset values.
  - p clears to 0 and the in-flight result is discarded. done does not pulse.
- Zero operand:
  - Still takes the full 32 iterations, so latency is data-independent.

## Configuration
- MUL_SIGNED_EN:
  - Defined: the sgn port exists.
    - When sgn=1 at acceptance:
      - mcand←|a| and lo←|b|, using two's-complement magnitude. 0x80000000 maps to magnitude 2^31, held unsigned in 32 bits.
      - A neg flag ← a[31]^b[31] is registered.
      - At the final CALC edge, p ← neg ? −{hi,lo} : {hi,lo}, taken modulo 2^64.
    - Latency is identical to the unsigned case.
    - When sgn=0, behaviour is exactly the unsigned path.
  - Undefined: there is no sgn port and no neg logic. All operations are unsigned.

## Test plan
- Reset, then a=3, b=5, start pulse at edge E:
  - done high in the cycle after edge E+32, p=0x000000000000000F, busy low after E+33.
- a=0xFFFFFFFF, b=0xFFFFFFFF:
  - p=0xFFFFFFFE00000001. This exercises the carry-out capture on every iteration.
- a=0, b=0x12345678:
  - p=0, done still at E+32, confirming fixed latency.
- a=7, b=9 accepted; at E+10, a=2, b=2 and start=1 are asserted:
  - the second request is ignored, p=0x3F, and exactly one done pulse occurs.
- a=7, b=9 accepted; rst pulsed at E+15:
  - p=0, busy=0, no done pulse.
  - A fresh start with a=6, b=6 then yields p=0x24 after 32 iterations.
- MUL_SIGNED_EN defined, sgn=1:
  - a=0xFFFFFFFD (−3), b=5 → p=0xFFFFFFFFFFFFFFF1.
  - a=0x80000000, b=0x80000000 → p=0x4000000000000000.
